mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 14 +
 rtl/mux_arbiter_mux_w.sv | 13 +
 rtl/mux_arbiter.sv | 134 +++++++++++++
 tb/tb_mux_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic SRC_A  = 1'b0;
  localparam logic SRC_B  = 1'b1;
  localparam int   HOLD_W = 4;

endpackage

// File: rtl/mux_arbiter_mux_w.sv
// DATA_W-wide 2:1 data mux; sel = 0 picks a, sel = 1 picks b.
module mux_w #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Two-source arbiter with a bounded-hold fairness rule feeding one output stream.
// Grant and last-served state are registered; data path is a zero-latency mux.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              sel,
  output state_t            dbg_state,
  output logic [HOLD_W-1:0] dbg_hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              r_state;
  state_t              w_state_d;
  logic                r_last_served;
  logic                w_last_served_d;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_cnt_d;

  // Handshake: a beat moves when out_valid & out_ready; the requester keeps
  // req/data stable until its ack, and dropping req earlier withdraws it.
  assign gnt_a     = (r_state == GRANT_A);
  assign gnt_b     = (r_state == GRANT_B);
  assign sel       = gnt_b;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign ack_a     = gnt_a & req_a & out_ready;
  assign ack_b     = gnt_b & req_b & out_ready;

  assign dbg_state    = r_state;
  assign dbg_hold_cnt = r_hold_cnt;

  mux_w #(.W(DATA_W)) u_mux (
    .sel (sel),
    .a   (data_a),
    .b   (data_b),
    .y   (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_served <= SRC_B;
      r_hold_cnt    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_last_served <= w_last_served_d;
      r_hold_cnt    <= w_hold_cnt_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_last_served_d = r_last_served;
    w_hold_cnt_d    = r_hold_cnt;
    case (r_state)
      IDLE: begin
        // On a tie, the source not served last wins.
        if (req_a && (!req_b || (r_last_served == SRC_B))) begin
          w_state_d       = GRANT_A;
          w_last_served_d = SRC_A;
          w_hold_cnt_d    = '0;
        end else if (req_b) begin
          w_state_d       = GRANT_B;
          w_last_served_d = SRC_B;
          w_hold_cnt_d    = '0;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          if (req_b) begin
            w_state_d       = GRANT_B;
            w_last_served_d = SRC_B;
          end else begin
            w_state_d = IDLE;
          end
          w_hold_cnt_d = '0;
        end else if (out_ready) begin
          if (r_hold_cnt >= HOLD_LAST) begin
            // Saturate while B is quiet; hand over once it is waiting.
            if (req_b) begin
              w_state_d       = GRANT_B;
              w_last_served_d = SRC_B;
              w_hold_cnt_d    = '0;
            end
          end else begin
            w_hold_cnt_d = r_hold_cnt + 1'b1;
          end
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          if (req_a) begin
            w_state_d       = GRANT_A;
            w_last_served_d = SRC_A;
          end else begin
            w_state_d = IDLE;
          end
          w_hold_cnt_d = '0;
        end else if (out_ready) begin
          if (r_hold_cnt >= HOLD_LAST) begin
            if (req_a) begin
              w_state_d       = GRANT_A;
              w_last_served_d = SRC_A;
              w_hold_cnt_d    = '0;
            end
          end else begin
            w_hold_cnt_d = r_hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_d    = IDLE;
        w_hold_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: scenario tasks plus an ack-driven scoreboard.
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;
  localparam int W        = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_a, req_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              gnt_a, gnt_b, ack_a, ack_b, sel;
  state_t            dbg_state;
  logic [3:0]        dbg_hold_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] pay_a[16];
  logic [DATA_W-1:0] pay_b[16];
  int                na, nb, ia, ib;
  bit                rnd_ready;

  mux_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_a        (req_a),
    .req_b        (req_b),
    .data_a       (data_a),
    .data_b       (data_b),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .gnt_a        (gnt_a),
    .gnt_b        (gnt_b),
    .ack_a        (ack_a),
    .ack_b        (ack_b),
    .sel          (sel),
    .dbg_state    (dbg_state),
    .dbg_hold_cnt (dbg_hold_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    n_assert++;
    if (gnt_a && gnt_b) begin
      n_fail++;
      $display("FAIL both_grants: gnt_a=%0b gnt_b=%0b required not both 1", gnt_a, gnt_b);
    end
    n_assert++;
    if (sel !== gnt_b) begin
      n_fail++;
      $display("FAIL sel_eq_gnt_b: sel=%0b required %0b", sel, gnt_b);
    end
    if (ack_a || ack_b) begin
      act_v = {ack_b, out_data};
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got src=%0b data=%h with nothing expected", ack_b, out_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL sb_transfer: got src=%0b data=%h required src=%0b data=%h",
                   act_v[W-1], act_v[DATA_W-1:0], exp_v[W-1], exp_v[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic src, input logic [DATA_W-1:0] d);
    exp_q.push_back({src, d});
  endtask

  task automatic fill_payloads();
    for (int i = 0; i < 16; i++) begin
      pay_a[i] = DATA_W'($urandom_range(0, 255));
      pay_b[i] = DATA_W'($urandom_range(0, 255));
    end
  endtask

  // Each source keeps requesting until its quota of transfers is acked.
  task automatic run_stream(input int budget);
    int cyc;
    cyc = 0;
    ia = 0; ib = 0;
    while ((ia < na || ib < nb) && cyc < budget) begin
      req_a     = (ia < na);
      req_b     = (ib < nb);
      data_a    = pay_a[ia];
      data_b    = pay_b[ib];
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (ack_a) ia++;
      if (ack_b) ib++;
      @(posedge clk);
      #1 cyc++;
    end
    req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    n_assert++;
    if (ia != na || ib != nb) begin
      n_fail++;
      $display("FAIL stream_timeout: acked a=%0d b=%0d required a=%0d b=%0d", ia, ib, na, nb);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    data_a = 8'hA5; data_b = 8'h5A;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({gnt_a, gnt_b, sel} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_grants: gnt_a/gnt_b/sel=%b required 000", {gnt_a, gnt_b, sel});
    end
    n_assert++;
    if ({out_valid, ack_a, ack_b} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valid_ack: valid/ack_a/ack_b=%b required 000", {out_valid, ack_a, ack_b});
    end
    n_assert++;
    if (dbg_state !== IDLE || dbg_hold_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d hold=%0d required 0 0", dbg_state, dbg_hold_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_single_a();
    req_a = 1'b1; data_a = 8'h11; out_ready = 1'b1;
    @(negedge clk);
    n_assert++;
    if (dbg_state !== IDLE || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: state=%0d valid=%0b required 0 0", dbg_state, out_valid);
    end
    repeat (3) push_exp(SRC_A, 8'h11);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n_assert++;
      if ({gnt_a, out_valid, ack_a} !== 3'b111 || out_data !== 8'h11) begin
        n_fail++;
        $display("FAIL single_xfer: gnt/valid/ack=%b data=%h required 111 11",
                 {gnt_a, out_valid, ack_a}, out_data);
      end
    end
    @(posedge clk);
    #1 req_a = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL single_to_idle: state=%0d required %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_tie();
    apply_reset();
    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_first: gnt_a/gnt_b=%b required 10", {gnt_a, gnt_b});
    end
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL tie_idle: state=%0d required %0d", dbg_state, IDLE);
    end
    req_a = 1'b1; req_b = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_second: gnt_a/gnt_b=%b required 01", {gnt_a, gnt_b});
    end
    req_b = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL withdraw_switch: gnt_a/gnt_b=%b required 10", {gnt_a, gnt_b});
    end
    req_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rotation();
    apply_reset();
    fill_payloads();
    na = 8; nb = 8; rnd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(SRC_A, pay_a[i]);
    for (int i = 0; i < 4; i++) push_exp(SRC_B, pay_b[i]);
    for (int i = 4; i < 8; i++) push_exp(SRC_A, pay_a[i]);
    for (int i = 4; i < 8; i++) push_exp(SRC_B, pay_b[i]);
    run_stream(60);
    @(posedge clk);
    #1;
    n_assert++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL rotation_idle: state=%0d required %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] x, y;
    apply_reset();
    x = DATA_W'($urandom_range(0, 255));
    y = ~x;
    req_a = 1'b1; data_a = x; req_b = 1'b1; data_b = y; out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_assert++;
      if ({gnt_a, gnt_b, sel, ack_a, ack_b} !== 5'b10000 || out_data !== x || dbg_hold_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL stall_hold: gnt_a/gnt_b/sel/ack_a/ack_b=%b data=%h hold=%0d required 10000 %h 0",
                 {gnt_a, gnt_b, sel, ack_a, ack_b}, out_data, dbg_hold_cnt, x);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    push_exp(SRC_A, x);
    @(negedge clk);
    n_assert++;
    if (ack_a !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: ack_a=%0b required 1", ack_a);
    end
    @(posedge clk);
    #1 req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fill_payloads();
    na = 6; nb = 5; rnd_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(SRC_A, pay_a[i]);
    for (int i = 0; i < 4; i++) push_exp(SRC_B, pay_b[i]);
    push_exp(SRC_A, pay_a[4]);
    push_exp(SRC_A, pay_a[5]);
    push_exp(SRC_B, pay_b[4]);
    run_stream(400);
    @(posedge clk);
    #1;
    n_assert++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL b2b_idle: state=%0d required %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_saturate();
    int exp_hold;
    apply_reset();
    fill_payloads();
    for (int i = 0; i < 10; i++) push_exp(SRC_A, pay_a[i]);
    req_a = 1'b1; out_ready = 1'b1; data_a = pay_a[0];
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      data_a = pay_a[k];
      exp_hold = (k < MAX_HOLD - 1) ? k : MAX_HOLD - 1;
      @(negedge clk);
      n_assert++;
      if ({gnt_a, ack_a} !== 2'b11 || dbg_hold_cnt !== 4'(exp_hold)) begin
        n_fail++;
        $display("FAIL saturate_hold: gnt_a/ack_a=%b hold=%0d required 11 %0d",
                 {gnt_a, ack_a}, dbg_hold_cnt, exp_hold);
      end
      @(posedge clk);
      #1;
    end
    req_a = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] x, y;
    apply_reset();
    x = DATA_W'($urandom_range(0, 255));
    y = x ^ 8'h3C;
    req_a = 1'b1; data_a = x; out_ready = 1'b1;
    push_exp(SRC_A, x);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1 data_a = y;
    #1 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({gnt_a, out_valid, ack_a} !== 3'b000 || dbg_state !== IDLE || dbg_hold_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: gnt_a/valid/ack_a=%b state=%0d hold=%0d required 000 0 0",
               {gnt_a, out_valid, ack_a}, dbg_state, dbg_hold_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; req_b = 1'b1; data_b = ~y; out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: gnt_a/gnt_b=%b required 10", {gnt_a, gnt_b});
    end
    push_exp(SRC_A, y);
    out_ready = 1'b1;
    @(negedge clk);
    n_assert++;
    if (ack_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ack: ack_a=%0b required 1", ack_a);
    end
    @(posedge clk);
    #1 req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; out_ready = 1'b0;
    rst_n = 1'b0; rnd_ready = 1'b0;
    na = 0; nb = 0; ia = 0; ib = 0;
    test_reset();
    test_single_a();
    test_tie();
    test_rotation();
    test_stall();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected transfers never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
